hex_display_ctrl: RTL

Memory-mapped controller for a bank of seven-segment digits, sitting on the processor's shared address/data bus alongside the other I/O devices. It generalises the fixed six-digit hex display to a configurable digit count and adds per-digit blanking, per-digit blinking driven by an internal prescaler, and full register readback. Segment outputs are registered, active-low, and drive the board's HEX pins directly.

---
 rtl/hex_display_pkg.sv | 20 ++
 rtl/hex_display_ctrl_if.sv | 10 +
 rtl/seven_seg_decode.sv | 9 +
 rtl/hex_display_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared constants for the seven-segment display controller: register offsets,
// CTRL field positions and the active-low glyph table (bit order g..a).
package hex_display_pkg;

  localparam int unsigned OFS_DATA   = 0;
  localparam int unsigned OFS_CTRL   = 4;
  localparam int unsigned OFS_STATUS = 8;

  localparam int unsigned CTRL_BLANK_LSB   = 0;
  localparam int unsigned CTRL_BLINK_LSB   = 8;
  localparam int unsigned CTRL_RESTART_BIT = 31;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Address/strobe half of the shared processor bus as seen by the display controller.
interface hex_display_ctrl_if #(
  parameter int BITS = 32
);
  logic [BITS-1:0] ABUS;
  logic            WE;

  modport master (output ABUS, output WE);
  modport slave  (input  ABUS, input  WE);
endinterface

// File: rtl/seven_seg_decode.sv
// Hex nibble to active-low seven-segment glyph, purely combinational.
module seven_seg_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = GLYPH[nibble];
endmodule

// File: rtl/hex_display_ctrl.sv
// Memory-mapped NDIGITS seven-segment controller with blanking and blinking.
// Define HEX_DISPLAY_BLINK_EN to build the blink prescaler, phase and blink mask.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int          BITS      = 32,
  parameter logic [31:0] BASE      = 32'hF000_0000,
  parameter int          NDIGITS   = 6,
  parameter logic [31:0] RESET_VAL = 32'h00FE_DEAD,
  parameter int          BLINK_DIV = 25000000
) (
  input  logic                 CLK,
  input  logic                 RESET,
  hex_display_ctrl_if.slave    bus,
  inout  wire  [BITS-1:0]      DBUS,
  output logic [7*NDIGITS-1:0] HEX
);

  localparam int DW = 4 * NDIGITS;
  localparam logic [BITS-1:0] A_DATA   = BITS'(BASE) + BITS'(OFS_DATA);
  localparam logic [BITS-1:0] A_CTRL   = BITS'(BASE) + BITS'(OFS_CTRL);
  localparam logic [BITS-1:0] A_STATUS = BITS'(BASE) + BITS'(OFS_STATUS);

  logic [DW-1:0]      data_q;
  logic [NDIGITS-1:0] blank_q;
  logic [BITS-1:0]    rdata;
  logic [7*NDIGITS-1:0] glyph;
  logic [7*NDIGITS-1:0] seg_p0;

  wire hit_data   = (bus.ABUS == A_DATA);
  wire hit_ctrl   = (bus.ABUS == A_CTRL);
  wire hit_status = (bus.ABUS == A_STATUS);
  wire hit_any    = hit_data || hit_ctrl || hit_status;
  wire wr_data    = bus.WE && hit_data;
  wire wr_ctrl    = bus.WE && hit_ctrl;
  wire unused_dbus = ^DBUS;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      data_q  <= RESET_VAL[DW-1:0];
      blank_q <= '0;
    end else begin
      if (wr_data) data_q  <= DBUS[DW-1:0];
      if (wr_ctrl) blank_q <= DBUS[CTRL_BLANK_LSB +: NDIGITS];
    end
  end

`ifdef HEX_DISPLAY_BLINK_EN
  localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [CW-1:0]      cnt_q;
  logic               phase_q;
  logic [NDIGITS-1:0] blink_q;

  wire restart = wr_ctrl && DBUS[CTRL_RESTART_BIT];
  wire wrap    = (cnt_q == CW'(BLINK_DIV - 1));

  // Restart wins over the natural wrap so software gets a clean lit half-period.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      blink_q <= '0;
    end else begin
      if (wr_ctrl) blink_q <= DBUS[CTRL_BLINK_LSB +: NDIGITS];
      if (restart) begin
        cnt_q   <= '0;
        phase_q <= 1'b0;
      end else if (wrap) begin
        cnt_q   <= '0;
        phase_q <= ~phase_q;
      end else begin
        cnt_q   <= cnt_q + CW'(1);
      end
    end
  end
`else
  wire [NDIGITS-1:0] blink_q = '0;
  wire               phase_q = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (hit_data) begin
      rdata[DW-1:0] = data_q;
    end else if (hit_ctrl) begin
      rdata[CTRL_BLANK_LSB +: NDIGITS] = blank_q;
      rdata[CTRL_BLINK_LSB +: NDIGITS] = blink_q;
    end else if (hit_status) begin
      rdata[0] = phase_q;
    end
  end

  assign DBUS = (!bus.WE && hit_any) ? rdata : 'z;

  for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
    seven_seg_decode u_dec (
      .nibble (data_q[4*i +: 4]),
      .seg    (glyph[7*i +: 7])
    );
  end

  // Stage p0: per-digit masking ahead of the HEX output register.
  always_comb begin
    seg_p0 = '1;
    for (int i = 0; i < NDIGITS; i++) begin
      if (blank_q[i] || (blink_q[i] && phase_q)) seg_p0[7*i +: 7] = SEG_OFF;
      else                                       seg_p0[7*i +: 7] = glyph[7*i +: 7];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) HEX <= '1;
    else       HEX <= seg_p0;
  end

endmodule
